// File: rtl/sdcard_ctrlmod.sv
// sdcard_ctrlmod: SPI-mode SD card init sequencer and two-port sector arbiter in front of sdcard_basemod.
//
// Ports:
//   CLOCK, RESET      system clock, asynchronous active-low reset
//   iCall[1:0]        per-requester call, held until the matching oDone pulse
//   iWr[1:0]          per-requester direction (1 = write sector, 0 = read sector)
//   iSector[63:0]     sector numbers, [31:0] requester 0, [63:32] requester 1
//   iData[15:0]       write bytes, [7:0] requester 0, [15:8] requester 1
//   oDone, oErr       completion pulse and nonzero-R1 flag per requester
//   oWrEn, oRdEn      per-requester byte strobes (write consumed / read valid)
//   oData             read byte
//   oReady            init succeeded, requests accepted
//   oInitFail         init failed INIT_TRIES times, sticky until reset
//   oSDHC             CCS bit of the card OCR
//   BCall..BRdData    control and data interface of sdcard_basemod
module sdcard_ctrlmod #(
    parameter int INIT_TRIES = 3
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [1:0]  iCall,
    input  logic [1:0]  iWr,
    input  logic [63:0] iSector,
    input  logic [15:0] iData,
    output logic [1:0]  oDone,
    output logic [1:0]  oErr,
    output logic [1:0]  oWrEn,
    output logic [1:0]  oRdEn,
    output logic [7:0]  oData,
    output logic        oReady,
    output logic        oInitFail,
    output logic        oSDHC,
    output logic [7:0]  BCall,
    input  logic        BDone,
    input  logic [39:0] BTag,
    output logic [31:0] BAddr,
    output logic [1:0]  BEn,
    output logic [7:0]  BData,
    input  logic [7:0]  BRdData
);
    typedef enum logic [3:0] {
        I_CMD0, I_CMD8, I_CMD58A, I_ACMD41, I_CMD58B, I_CMD16,
        IDLE, W_FILL, W_CMD24, R_CMD17, R_DRAIN, FINISH, FAIL
    } state_t;

    state_t      state, next_init;
    logic        sel, last, r1_bad, g, init_ok, unused_tag;
    logic [8:0]  cnt;
    logic [1:0]  ph;
    logic [7:0]  tries, init_bit;
    logic [31:0] sector;

    // Only the R1, echo and CCS fields of the response tag are inspected.
    assign unused_tag = ^{BTag[31], BTag[29:12]};

    // Both calling: serve the one not served last; otherwise serve whoever calls.
    assign g      = (&iCall) ? ~last : iCall[1];
    assign sector = g ? iSector[63:32] : iSector[31:0];
    // The write byte is passed straight through while the buffer strobe is high.
    assign BData  = BEn[1] ? (sel ? iData[15:8] : iData[7:0]) : 8'h00;

    always_comb begin
        init_ok   = 1'b1;
        next_init = state;
        init_bit  = 8'h00;
        case (state)
            I_CMD0:   begin init_bit = 8'h01; init_ok = BTag[7:0] == 8'h01;    next_init = I_CMD8;   end
            I_CMD8:   begin init_bit = 8'h02; init_ok = BTag[11:0] == 12'h1AA; next_init = I_CMD58A; end
            I_CMD58A: begin init_bit = 8'h04;                                  next_init = I_ACMD41; end
            I_ACMD41: begin init_bit = 8'h08; init_ok = BTag[39:32] == 8'h00; next_init = I_CMD58B; end
            I_CMD58B: begin init_bit = 8'h10;                                  next_init = I_CMD16;  end
            I_CMD16:  begin init_bit = 8'h20; init_ok = BTag[7:0] == 8'h00;    next_init = IDLE;     end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state     <= I_CMD0;
            last      <= 1'b1;
            sel       <= 1'b0;
            r1_bad    <= 1'b0;
            cnt       <= '0;
            ph        <= '0;
            tries     <= '0;
            oDone     <= '0;
            oErr      <= '0;
            oWrEn     <= '0;
            oRdEn     <= '0;
            oData     <= '0;
            oReady    <= 1'b0;
            oInitFail <= 1'b0;
            oSDHC     <= 1'b0;
            BCall     <= '0;
            BAddr     <= '0;
            BEn       <= '0;
        end else begin
            oDone <= '0;
            oErr  <= '0;
            case (state)
                I_CMD0, I_CMD8, I_CMD58A, I_ACMD41, I_CMD58B, I_CMD16: begin
                    if (BCall == 8'h00) begin
                        BCall <= init_bit;
                    end else if (BDone) begin
                        BCall <= '0;
                        if (init_ok) begin
                            state <= next_init;
                            if (state == I_CMD58B) oSDHC <= BTag[30];
                            if (next_init == IDLE) oReady <= 1'b1;
                        end else if (tries == 8'(INIT_TRIES - 1)) begin
                            state     <= FAIL;
                            oInitFail <= 1'b1;
                        end else begin
                            tries <= tries + 8'd1;
                            state <= I_CMD0;
                        end
                    end
                end
                IDLE: if (|iCall) begin
                    sel   <= g;
                    last  <= g;
                    cnt   <= '0;
                    ph    <= '0;
                    BAddr <= oSDHC ? sector : {sector[22:0], 9'd0};
                    if (iWr[g]) begin
                        state <= W_FILL;
                        oWrEn <= {g, ~g};
                        BEn   <= 2'b10;
                    end else begin
                        state <= R_CMD17;
                        BCall <= 8'h40;
                    end
                end
                // Alternate strobe and idle cycles: 2 cycles per byte.
                W_FILL: begin
                    if (|oWrEn) begin
                        oWrEn <= '0;
                        BEn   <= '0;
                    end else if (cnt == 9'd511) begin
                        state <= W_CMD24;
                        BCall <= 8'h80;
                    end else begin
                        cnt   <= cnt + 9'd1;
                        oWrEn <= {sel, ~sel};
                        BEn   <= 2'b10;
                    end
                end
                W_CMD24: if (BDone) begin
                    BCall      <= '0;
                    state      <= FINISH;
                    oDone[sel] <= 1'b1;
                    oErr[sel]  <= |BTag[7:0];
                end
                R_CMD17: if (BDone) begin
                    BCall  <= '0;
                    r1_bad <= |BTag[7:0];
                    state  <= R_DRAIN;
                    BEn    <= 2'b01;
                end
                // Strobe, wait one cycle for the buffer, then present the byte: 3 cycles per byte.
                R_DRAIN: begin
                    if (ph == 2'd0) begin
                        BEn <= '0;
                        ph  <= 2'd1;
                    end else if (ph == 2'd1) begin
                        oData <= BRdData;
                        oRdEn <= {sel, ~sel};
                        ph    <= 2'd2;
                    end else begin
                        oRdEn <= '0;
                        ph    <= 2'd0;
                        if (cnt == 9'd511) begin
                            state      <= FINISH;
                            oDone[sel] <= 1'b1;
                            oErr[sel]  <= r1_bad;
                        end else begin
                            cnt <= cnt + 9'd1;
                            BEn <= 2'b01;
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sdcard_ctrlmod.sv
// tb_sdcard_ctrlmod: directed bench for sdcard_ctrlmod with a behavioural sdcard_basemod model.
module tb_sdcard_ctrlmod;
    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic [1:0]  iCall = '0;
    logic [1:0]  iWr = '0;
    logic [63:0] iSector = '0;
    logic [15:0] iData = '0;
    logic [1:0]  oDone, oErr, oWrEn, oRdEn;
    logic [7:0]  oData;
    logic        oReady, oInitFail, oSDHC;
    logic [7:0]  BCall;
    logic        BDone = 1'b0;
    logic [39:0] BTag = '0;
    logic [31:0] BAddr;
    logic [1:0]  BEn;
    logic [7:0]  BData;
    logic [7:0]  BRdData = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0]  cmd0_r1 = 8'h01;
    logic [7:0]  cmd17_r1 = 8'h00;
    logic [7:0]  cmd24_r1 = 8'h00;
    logic [31:0] ocr = 32'hC0FF8000;
    logic [7:0]  wbuf [512];
    logic [7:0]  rbuf [512];
    int          calls [64];
    int          nlog = 0;
    int          wptr = 0;
    int          rptr = 0;
    int          lat = 0;
    logic        multi_hot = 1'b0;

    sdcard_ctrlmod #(.INIT_TRIES(3)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .iCall(iCall), .iWr(iWr), .iSector(iSector),
        .iData(iData), .oDone(oDone), .oErr(oErr), .oWrEn(oWrEn), .oRdEn(oRdEn),
        .oData(oData), .oReady(oReady), .oInitFail(oInitFail), .oSDHC(oSDHC),
        .BCall(BCall), .BDone(BDone), .BTag(BTag), .BAddr(BAddr), .BEn(BEn),
        .BData(BData), .BRdData(BRdData)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;
    always @(negedge CLOCK) if ($countones(BCall) > 1) multi_hot <= 1'b1;

    function automatic logic [39:0] resp(input logic [7:0] c);
        if (c[0]) return {32'h0, cmd0_r1};
        if (c[1]) return 40'h01_000001AA;
        if (c[2] || c[4]) return {8'h00, ocr};
        if (c[6]) return {32'h0, cmd17_r1};
        if (c[7]) return {32'h0, cmd24_r1};
        return 40'h0;
    endfunction

    function automatic int idx(input logic [7:0] c);
        for (int i = 0; i < 8; i++) if (c[i]) return i;
        return -1;
    endfunction

    // Base module model: answers each call 4 cycles after it rises, buffers bytes on BEn strobes.
    always @(posedge CLOCK) begin
        if (!RESET) begin
            BDone <= 1'b0;
            lat   <= 0;
            nlog  <= 0;
            wptr  <= 0;
            rptr  <= 0;
        end else begin
            if (BDone) begin
                BDone <= 1'b0;
                lat   <= 0;
            end else if (BCall != 8'h00) begin
                if (lat == 3) begin
                    BDone <= 1'b1;
                    BTag  <= resp(BCall);
                    if (nlog < 64) calls[nlog] <= idx(BCall);
                    nlog <= nlog + 1;
                    if (BCall[6]) rptr <= 0;
                end else lat <= lat + 1;
            end
            if (BEn[1] && wptr < 512) begin
                wbuf[wptr] <= BData;
                wptr <= wptr + 1;
            end
            if (BEn[0]) begin
                BRdData <= rbuf[rptr % 512];
                rptr <= rptr + 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b0;
        iCall = '0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic wait_ready(input int budget);
        for (int t = 0; t < budget && !oReady && !oInitFail; t++) @(negedge CLOCK);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLOCK);
        vectors++; if (BCall !== 8'h00) begin miscompares++; $display("FAIL reset_bcall: got %h want 00", BCall); end
        vectors++; if (BEn !== 2'b00) begin miscompares++; $display("FAIL reset_ben: got %b want 00", BEn); end
        vectors++; if (oReady !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", oReady); end
        vectors++; if ({oDone, oErr, oWrEn, oRdEn} !== 8'h00) begin miscompares++; $display("FAIL reset_strobes: got %h want 00", {oDone, oErr, oWrEn, oRdEn}); end
        vectors++; if ({oInitFail, oSDHC} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {oInitFail, oSDHC}); end
        vectors++; if (BAddr !== 32'h0) begin miscompares++; $display("FAIL reset_baddr: got %h want 0", BAddr); end
    endtask

    task automatic test_init_good();
        @(negedge CLOCK);
        RESET = 1'b1;
        wait_ready(1000);
        vectors++; if (oReady !== 1'b1) begin miscompares++; $display("FAIL init_ready: got %b want 1", oReady); end
        vectors++; if (oInitFail !== 1'b0) begin miscompares++; $display("FAIL init_nofail: got %b want 0", oInitFail); end
        vectors++; if (oSDHC !== 1'b1) begin miscompares++; $display("FAIL init_sdhc: got %b want 1", oSDHC); end
        vectors++; if (nlog !== 6) begin miscompares++; $display("FAIL init_calls: got %0d want 6", nlog); end
        for (int i = 0; i < 6; i++) begin
            vectors++; if (calls[i] !== i) begin miscompares++; $display("FAIL init_order[%0d]: got %0d want %0d", i, calls[i], i); end
        end
    endtask

    task automatic test_read();
        int c0, first_call, bd, first_rd, last_rd, n, bad_data, bad_gap, stray, done, err;
        logic [31:0] addr;
        first_call = -1; bd = -1; first_rd = -1; last_rd = 0; n = 0;
        bad_data = 0; bad_gap = 0; stray = 0; done = 0; err = 0; addr = '0;
        cmd17_r1 = 8'h04;
        @(negedge CLOCK);
        iSector[63:32] = 32'd7;
        iWr = 2'b00;
        iCall = 2'b10;
        c0 = cyc;
        for (int t = 0; t < 3000 && done == 0; t++) begin
            @(negedge CLOCK);
            if (BCall[6] && first_call < 0) begin first_call = cyc - c0; addr = BAddr; end
            if (BDone && BCall[6]) bd = cyc;
            if (oRdEn[1]) begin
                if (n == 0) first_rd = cyc - bd;
                else if (cyc - last_rd != 3) bad_gap++;
                if (oData !== n[7:0]) bad_data++;
                last_rd = cyc;
                n++;
            end
            if (oRdEn[0] || oWrEn != 2'b00) stray++;
            if (oDone[1]) begin done = 1; err = int'(oErr[1]); iCall[1] = 1'b0; end
        end
        cmd17_r1 = 8'h00;
        vectors++; if (first_call !== 1) begin miscompares++; $display("FAIL rd_grant_latency: got %0d want 1", first_call); end
        vectors++; if (addr !== 32'd7) begin miscompares++; $display("FAIL rd_baddr: got %h want 00000007", addr); end
        vectors++; if (first_rd !== 3) begin miscompares++; $display("FAIL rd_first_latency: got %0d want 3", first_rd); end
        vectors++; if (n !== 512) begin miscompares++; $display("FAIL rd_count: got %0d want 512", n); end
        vectors++; if (bad_data !== 0) begin miscompares++; $display("FAIL rd_data: got %0d bad bytes want 0", bad_data); end
        vectors++; if (bad_gap !== 0) begin miscompares++; $display("FAIL rd_spacing: got %0d bad gaps want 0", bad_gap); end
        vectors++; if (stray !== 0) begin miscompares++; $display("FAIL rd_stray: got %0d stray strobes want 0", stray); end
        vectors++; if (done !== 1) begin miscompares++; $display("FAIL rd_done: got %0d want 1", done); end
        vectors++; if (err !== 1) begin miscompares++; $display("FAIL rd_err: got %0d want 1", err); end
    endtask

    task automatic test_init_fail();
        int bad_call, bad_order;
        bad_call = 0; bad_order = 0;
        cmd0_r1 = 8'hFF;
        do_reset();
        wait_ready(1000);
        vectors++; if (oInitFail !== 1'b1) begin miscompares++; $display("FAIL fail_flag: got %b want 1", oInitFail); end
        vectors++; if (oReady !== 1'b0) begin miscompares++; $display("FAIL fail_ready: got %b want 0", oReady); end
        vectors++; if (nlog !== 3) begin miscompares++; $display("FAIL fail_calls: got %0d want 3", nlog); end
        for (int i = 0; i < 3; i++) if (calls[i] != 0) bad_order++;
        vectors++; if (bad_order !== 0) begin miscompares++; $display("FAIL fail_cmd0_only: got %0d other calls want 0", bad_order); end
        for (int t = 0; t < 50; t++) begin
            @(negedge CLOCK);
            if (BCall != 8'h00) bad_call++;
        end
        vectors++; if (bad_call !== 0) begin miscompares++; $display("FAIL fail_quiet: got %0d busy cycles want 0", bad_call); end
        vectors++; if (nlog !== 3) begin miscompares++; $display("FAIL fail_calls_after: got %0d want 3", nlog); end
        cmd0_r1 = 8'h01;
    endtask

    task automatic test_write_sdsc();
        int c0, w0, first_wr, last_wr, c24, n, bad_data, bad_gap, bad_buf, done, err, pending;
        logic [31:0] addr;
        first_wr = -1; w0 = 0; last_wr = 0; c24 = -1; n = 0; bad_data = 0; bad_gap = 0;
        bad_buf = 0; done = 0; err = -1; pending = 0; addr = '0;
        ocr = 32'h00FF8000;
        do_reset();
        wait_ready(1000);
        vectors++; if (oReady !== 1'b1) begin miscompares++; $display("FAIL wr_init_ready: got %b want 1", oReady); end
        vectors++; if (oSDHC !== 1'b0) begin miscompares++; $display("FAIL wr_sdsc: got %b want 0", oSDHC); end
        @(negedge CLOCK);
        iSector[31:0] = 32'd5;
        iWr = 2'b01;
        iData = 16'h0000;
        iCall = 2'b01;
        c0 = cyc;
        for (int t = 0; t < 3000 && done == 0; t++) begin
            @(negedge CLOCK);
            if (pending != 0) begin iData[7:0] = n[7:0]; pending = 0; end
            if (oWrEn[0]) begin
                if (n == 0) begin first_wr = cyc - c0; w0 = cyc; addr = BAddr; end
                else if (cyc - last_wr != 2) bad_gap++;
                if (BData !== n[7:0]) bad_data++;
                last_wr = cyc;
                n++;
                pending = 1;
            end
            if (BCall[7] && c24 < 0) c24 = cyc - w0;
            if (oDone[0]) begin done = 1; err = int'(oErr[0]); iCall[0] = 1'b0; end
        end
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            if (wbuf[i] !== v[7:0]) bad_buf++;
        end
        vectors++; if (first_wr !== 1) begin miscompares++; $display("FAIL wr_grant_latency: got %0d want 1", first_wr); end
        vectors++; if (addr !== 32'h0A00) begin miscompares++; $display("FAIL wr_baddr: got %h want 00000a00", addr); end
        vectors++; if (n !== 512) begin miscompares++; $display("FAIL wr_count: got %0d want 512", n); end
        vectors++; if (bad_data !== 0) begin miscompares++; $display("FAIL wr_bdata: got %0d bad bytes want 0", bad_data); end
        vectors++; if (bad_gap !== 0) begin miscompares++; $display("FAIL wr_spacing: got %0d bad gaps want 0", bad_gap); end
        vectors++; if (c24 !== 1024) begin miscompares++; $display("FAIL wr_cmd24_time: got %0d want 1024", c24); end
        vectors++; if (wptr !== 512 || bad_buf !== 0) begin miscompares++; $display("FAIL wr_buffer: got %0d bytes %0d bad want 512 0", wptr, bad_buf); end
        vectors++; if (done !== 1) begin miscompares++; $display("FAIL wr_done: got %0d want 1", done); end
        vectors++; if (err !== 0) begin miscompares++; $display("FAIL wr_err: got %0d want 0", err); end
        ocr = 32'hC0FF8000;
    endtask

    task automatic test_arb();
        int order [4];
        logic [31:0] addrs [4];
        int no, na, round, prev6;
        no = 0; na = 0; round = 0; prev6 = 0;
        for (int i = 0; i < 4; i++) begin order[i] = -1; addrs[i] = '0; end
        do_reset();
        wait_ready(1000);
        @(negedge CLOCK);
        iSector = {32'h20, 32'h10};
        iWr = 2'b00;
        iCall = 2'b11;
        for (int t = 0; t < 9000 && no < 4; t++) begin
            @(negedge CLOCK);
            if (round == 0 && no == 2) begin iCall = 2'b11; round = 1; end
            if (BCall[6] && prev6 == 0 && na < 4) begin addrs[na] = BAddr; na++; end
            prev6 = int'(BCall[6]);
            if (oDone[0]) begin order[no] = 0; no++; iCall[0] = 1'b0; end
            if (oDone[1]) begin order[no] = 1; no++; iCall[1] = 1'b0; end
        end
        vectors++; if (no !== 4) begin miscompares++; $display("FAIL arb_count: got %0d want 4", no); end
        vectors++; if ({order[0], order[1], order[2], order[3]} !== {32'sd0, 32'sd1, 32'sd0, 32'sd1}) begin
            miscompares++; $display("FAIL arb_order: got %0d %0d %0d %0d want 0 1 0 1", order[0], order[1], order[2], order[3]);
        end
        vectors++; if ({addrs[0], addrs[1], addrs[2]} !== {32'h10, 32'h20, 32'h10}) begin
            miscompares++; $display("FAIL arb_addr: got %h %h %h want 10 20 10", addrs[0], addrs[1], addrs[2]);
        end
    endtask

    task automatic test_reset_mid();
        int n, saw_done;
        n = 0; saw_done = 0;
        @(negedge CLOCK);
        iSector[31:0] = 32'd3;
        iWr = 2'b01;
        iData = 16'h00A5;
        iCall = 2'b01;
        for (int t = 0; t < 600 && n <= 100; t++) begin
            @(negedge CLOCK);
            if (oWrEn[0]) n++;
        end
        vectors++; if (n !== 101) begin miscompares++; $display("FAIL mid_reach_byte100: got %0d want 101", n); end
        RESET = 1'b0;
        iCall = '0;
        @(posedge CLOCK);
        #1;
        vectors++; if ({BCall, BEn, oWrEn, oRdEn, oDone} !== 16'h0000) begin
            miscompares++; $display("FAIL mid_outputs_zero: got %h want 0000", {BCall, BEn, oWrEn, oRdEn, oDone});
        end
        vectors++; if ({oReady, oSDHC, BData, BAddr} !== 42'h0) begin
            miscompares++; $display("FAIL mid_regs_zero: got %h want 0", {oReady, oSDHC, BData, BAddr});
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        for (int t = 0; t < 1000 && !oReady; t++) begin
            @(negedge CLOCK);
            if (oDone != 2'b00) saw_done++;
        end
        vectors++; if (saw_done !== 0) begin miscompares++; $display("FAIL mid_no_done: got %0d want 0", saw_done); end
        vectors++; if (nlog !== 6 || calls[0] !== 0) begin miscompares++; $display("FAIL mid_reinit: got %0d calls first %0d want 6 0", nlog, calls[0]); end
        vectors++; if (oReady !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b want 1", oReady); end
        vectors++; if (multi_hot !== 1'b0) begin miscompares++; $display("FAIL onehot_bcall: got %b want 0", multi_hot); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            rbuf[i] = v[7:0];
            wbuf[i] = 8'h00;
        end
        for (int i = 0; i < 64; i++) calls[i] = -1;
        test_reset();
        test_init_good();
        test_read();
        test_init_fail();
        test_write_sdsc();
        test_arb();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sdcard_ctrlmod.md
# sdcard_ctrlmod

Sequencer and two-port arbiter for `sdcard_basemod`. After reset it autonomously runs the SPI-mode card initialisation (CMD0, CMD8, CMD58, CMD55+ACMD41, CMD58, CMD16) and checks each response. It then shares the card between two block-level requesters, each issuing 512-byte sector reads or writes. It owns every `sdcard_basemod` control input (iCall, iAddr, iEn, iData); requesters never touch the base module directly.

## Interface
- INIT_TRIES, 3, full init sequences attempted before declaring failure
- CLOCK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- iCall  in  2  per-requester call; bit k held high until oDone[k]
- iWr  in  2  per-requester direction, 1=write sector, 0=read; stable while iCall[k] high
- iSector  in  64  packed sector numbers, [31:0] requester 0, [63:32] requester 1
- iData  in  16  packed write bytes, [7:0] req 0, [15:8] req 1; sampled on oWrEn[k]
- oDone  out  2  one-cycle completion pulse per requester
- oErr  out  2  valid with oDone[k]; 1 = card returned nonzero R1
- oWrEn  out  2  one-cycle pulse: iData byte of req k consumed this cycle
- oRdEn  out  2  one-cycle pulse: oData valid for req k this cycle
- oData  out  8  read byte
- oReady  out  1  init succeeded, requests accepted
- oInitFail  out  1  init failed INIT_TRIES times; sticky until reset
- oSDHC  out  1  OCR CCS bit from second CMD58
- BCall  out  8  to basemod iCall (bit0 CMD0, 1 CMD8, 2 CMD58, 3 ACMD41, 4 CMD58, 5 CMD16, 6 CMD17, 7 CMD24)
- BDone  in  1  from basemod oDone
- BTag  in  40  from basemod oTag; R1 in [39:32] (CMD0/CMD16/CMD17/CMD24: [7:0])
- BAddr  out  32  to basemod iAddr
- BEn  out  2  to basemod iEn; bit1 write-buffer strobe, bit0 read-buffer strobe
- BData  out  8  to basemod iData
- BRdData  in  8  from basemod oData

## Operation
- States: I_CMD0, I_CMD8, I_CMD58A, I_ACMD41, I_CMD58B, I_CMD16, IDLE, W_FILL, W_CMD24, R_CMD17, R_DRAIN, FINISH, FAIL.
- Base-module call rule: hold one BCall bit high until BDone seen; on that cycle clear the bit, latch BTag and advance. Exactly one BCall bit is high at any time.
- Init checks:
  - CMD0: BTag[7:0]==8'h01.
  - CMD8: BTag[11:0]==12'h1AA.
  - ACMD41: BTag[39:32]==8'h00.
  - CMD58B: oSDHC<=BTag[30].
  - CMD16: BTag[7:0]==8'h00.
  - CMD58A is unchecked.
- Init failure: any failed check restarts at I_CMD0 and increments the try counter. After INIT_TRIES failures, enter FAIL: oInitFail=1, no further activity.
- Init success: set oReady and go to IDLE.
- IDLE arbitration is round-robin with a last-grant pointer; after reset the pointer favours requester 0.
  - Simultaneous iCall: grant the requester not last served.
  - A single request is granted immediately.
  - Requests are ignored outside IDLE.
- Address: BAddr = oSDHC ? sector : sector<<9 (32-bit, upper bits truncated). Latched at grant.
- Write transaction, 512 bytes, byte counter 0..511:
  - W_FILL, per byte: cycle A drives oWrEn[k]=1, BData=iData[k], BEn[1]=1; cycle B is idle.
  - Then W_CMD24 with BCall[7].
- Read transaction:
  - R_CMD17 with BCall[6].
  - R_DRAIN, per byte: cycle A BEn[0]=1; cycle B idle; cycle C oData<=BRdData, oRdEn[k]=1.
- FINISH: oDone[k]=1 for one cycle. oErr[k]=(R1!=0) for the sector command. Return to IDLE.
- Nonzero R1 on CMD17 still completes the 512-byte drain; bytes are undefined.

## Timing
- Reset values: every output and internal register 0, except the RR pointer, which favours requester 0. The state machine returns to I_CMD0 on reset, including mid-transfer. BCall/BEn drop immediately; no oDone is issued for an aborted transfer.
- Write byte rate: 2 cycles/byte. Fill takes 1024 cycles before BCall[7] rises.
- Read byte rate: 3 cycles/byte. The first oRdEn comes 3 cycles after the BDone of CMD17.
- Grant latency: first oWrEn / BCall[6] appears 1 cycle after IDLE samples iCall.
- IDLE is re-entered 1 cycle after oDone. Requester k must drop iCall on the cycle it sees oDone[k], so it is never re-granted on a stale call.
- oWrEn and oRdEn are mutually exclusive across requesters and never both high.

## Test plan
- Good-card model (CMD0→01, CMD8→000001AA tail, ACMD41 R1=00, OCR=C0FF8000, CMD16→00) -> exactly 6 BCall pulses in bit order 0,1,2,3,4,5; oReady=1; oSDHC=1.
- CMD0 returns 8'hFF always, INIT_TRIES=3 -> 3 CMD0 calls; oInitFail=1; oReady=0; BCall stays 0 afterwards.
- SDSC card (OCR bit30=0), requester 0 writes sector 5 with bytes 00..FF,00..FF -> BAddr=32'h0A00; 512 oWrEn[0] pulses spaced 2 cycles; BData sequence matches; oDone[0]=1, oErr[0]=0.
- Both iCall rise on the same cycle after reset -> requester 0 served first, then requester 1; then both again -> requester 1 is not served first twice in a row (order 0,1,0,1).
- Requester 1 reads sector 7 on SDHC, model buffer holds 00..FF pattern -> BAddr=7; 512 oRdEn[1] pulses, oData 00,01,...,FF,00,...; CMD17 R1=04 -> oErr[1]=1 with oDone[1].
- RESET low during byte 100 of W_FILL -> all outputs 0 next edge; after release, init restarts at CMD0 with no oDone.
